// File: rtl/montre_de1_cpu_oci_trace_monitor.sv
// OCI trace monitor: captures dct words into a FIFO and tracks test lifecycle.
// Optional range check on dct_count enabled by defining OCI_TRACE_CHECK_EN.
module montre_de1_cpu_oci_trace_monitor #(
  parameter int SLOT_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          arm,
  input  logic                          dct_valid,
  input  logic [SLOT_W*SLOTS-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]              dct_count,
  input  logic                          test_ending,
  input  logic                          test_has_ended,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [CNT_W+SLOT_W*SLOTS-1:0] rd_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic [1:0]                    state_o,
  output logic                          done,
  output logic                          proto_err
);

  localparam int BUF_W = SLOT_W * SLOTS;
  localparam int ENT_W = CNT_W + BUF_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  logic            ended_seen;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [ENT_W-1:0] mem [DEPTH];

  logic          restart;
  logic          push_q;
  logic          bad;
  logic          push_ok;
  logic          full;
  logic          pop_ok;
  logic          wr_en;
  logic          drop;
  logic [LW-1:0] lvl_nxt;

  assign restart = arm && (state == IDLE || state == DONE);
  assign push_q  = (state == CAPTURE) && dct_valid && (dct_count != '0);
  assign push_ok = push_q && !bad;
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = rd_req && (level != '0) && !restart;
  // A full FIFO still accepts a push when a pop frees a slot this cycle
  assign wr_en   = push_ok && (!full || pop_ok);
  assign drop    = push_ok && full && !pop_ok;
  assign state_o = state;

`ifdef OCI_TRACE_CHECK_EN
  assign bad = push_q && (dct_count > CNT_W'(SLOTS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (restart) begin
      proto_err <= 1'b0;
    end else if (bad) begin
      proto_err <= 1'b1;
    end
  end
`else
  assign bad       = 1'b0;
  assign proto_err = 1'b0;
`endif

  always_comb begin
    lvl_nxt = level;
    if (wr_en && !pop_ok) begin
      lvl_nxt = level + 1'b1;
    end else if (!wr_en && pop_ok) begin
      lvl_nxt = level - 1'b1;
    end
  end

  // DONE is entered on the same edge that empties the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      ended_seen <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            state      <= CAPTURE;
            ended_seen <= 1'b0;
          end
        end
        CAPTURE: begin
          if (test_has_ended) begin
            ended_seen <= 1'b1;
          end
          if (test_ending || test_has_ended) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (test_has_ended) begin
            ended_seen <= 1'b1;
          end
          if (ended_seen && lvl_nxt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (arm) begin
            state      <= CAPTURE;
            done       <= 1'b0;
            ended_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {dct_count, dct_buffer};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) begin
        rd_data <= mem[rd_ptr];
      end
      if (restart) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        level <= lvl_nxt;
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_montre_de1_cpu_oci_trace_monitor.sv
// Directed bench for the OCI trace monitor.
// Second instance (SLOTS=14, DEPTH=4) exercises the count range check.
module tb_montre_de1_cpu_oci_trace_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm, dct_valid, test_ending, test_has_ended, rd_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        rd_valid, overflow, done, proto_err;
  logic [33:0] rd_data;
  logic [4:0]  level;
  logic [15:0] drop_cnt;
  logic [1:0]  state_o;

  logic        b_arm, b_valid, b_rd_req;
  logic [27:0] b_buf;
  logic [3:0]  b_cnt;
  logic        b_rd_valid, b_overflow, b_done, b_perr;
  logic [31:0] b_rd_data;
  logic [2:0]  b_level;
  logic [15:0] b_drop;
  logic [1:0]  b_state;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  montre_de1_cpu_oci_trace_monitor dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt),
    .state_o(state_o), .done(done), .proto_err(proto_err)
  );

  montre_de1_cpu_oci_trace_monitor #(
    .SLOT_W(2), .SLOTS(14), .CNT_W(4), .DEPTH(4), .DROP_W(16)
  ) u_chk (
    .clk(clk), .reset_n(reset_n), .arm(b_arm), .dct_valid(b_valid),
    .dct_buffer(b_buf), .dct_count(b_cnt),
    .test_ending(1'b0), .test_has_ended(1'b0),
    .rd_req(b_rd_req), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .level(b_level), .overflow(b_overflow), .drop_cnt(b_drop),
    .state_o(b_state), .done(b_done), .proto_err(b_perr)
  );

  function automatic logic [33:0] ent(input logic [3:0] c,
                                      input logic [29:0] b);
    return {c, b};
  endfunction

  function automatic logic [3:0] wcnt(input int i);
    return 4'(1 + (i % 15));
  endfunction

  function automatic logic [29:0] wbuf(input int i);
    return 30'(i * 1000 + 7);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({state_o, level, rd_valid, overflow, done, proto_err} !== '0) begin
      errs++;
      $display("FAIL reset_flags got st=%0d lvl=%0d rv=%b ov=%b dn=%b pe=%b",
               state_o, level, rd_valid, overflow, done, proto_err);
    end
    checks++;
    if (rd_data !== 34'd0 || drop_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_data got rd=%h drop=%0d exp 0/0", rd_data, drop_cnt);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [29:0] bufs [3];
    bufs[0] = 30'h3FFFFFFF;
    bufs[1] = 30'h00000001;
    bufs[2] = 30'h15555555;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (state_o !== 2'd1) begin
      errs++;
      $display("FAIL arm_state got=%0d exp=1", state_o);
    end
    for (int i = 0; i < 3; i++) begin
      dct_valid = 1'b1;
      dct_count = 4'hF;
      dct_buffer = bufs[i];
      tick();
    end
    dct_valid = 1'b0;
    checks++;
    if (level !== 5'd3) begin
      errs++;
      $display("FAIL basic_level got=%0d exp=3", level);
    end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1;
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== ent(4'hF, bufs[i])) begin
        errs++;
        $display("FAIL basic_rd%0d got rv=%b d=%h exp rv=1 d=%h",
                 i, rd_valid, rd_data, ent(4'hF, bufs[i]));
      end
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_end got lvl=%0d rv=%b exp 0/0", level, rd_valid);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 20; i++) begin
      dct_valid = 1'b1;
      dct_count = wcnt(i);
      dct_buffer = wbuf(i);
      tick();
    end
    dct_valid = 1'b0;
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd4) begin
      errs++;
      $display("FAIL ovf got lvl=%0d ov=%b drop=%0d exp 16/1/4",
               level, overflow, drop_cnt);
    end
  endtask

  task automatic test_full_pushpop;
    logic [33:0] exp;
    dct_valid = 1'b1;
    dct_count = 4'd3;
    dct_buffer = 30'h2ABCDEF;
    rd_req = 1'b1;
    tick();
    dct_valid = 1'b0;
    checks++;
    if (level !== 5'd16 || drop_cnt !== 16'd4) begin
      errs++;
      $display("FAIL full_pp got lvl=%0d drop=%0d exp 16/4", level, drop_cnt);
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== ent(wcnt(0), wbuf(0))) begin
      errs++;
      $display("FAIL full_pp_rd got rv=%b d=%h exp=%h",
               rd_valid, rd_data, ent(wcnt(0), wbuf(0)));
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i == 16) ? ent(4'd3, 30'h2ABCDEF) : ent(wcnt(i), wbuf(i));
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errs++;
        $display("FAIL drain_seq%0d got rv=%b d=%h exp=%h",
                 i, rd_valid, rd_data, exp);
      end
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (level !== 5'd0) begin
      errs++;
      $display("FAIL full_pp_empty got lvl=%0d exp=0", level);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 5; i++) begin
      dct_valid = 1'b1;
      dct_count = 4'hF;
      dct_buffer = 30'(i + 1);
      tick();
    end
    dct_valid = 1'b0;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    checks++;
    if (state_o !== 2'd2 || level !== 5'd5 || done !== 1'b0) begin
      errs++;
      $display("FAIL drain_enter got st=%0d lvl=%0d dn=%b exp 2/5/0",
               state_o, level, done);
    end
    test_has_ended = 1'b1;
    dct_valid = 1'b1;
    arm = 1'b1;
    tick();
    test_has_ended = 1'b0;
    dct_valid = 1'b0;
    arm = 1'b0;
    checks++;
    if (state_o !== 2'd2 || level !== 5'd5 || drop_cnt !== 16'd4) begin
      errs++;
      $display("FAIL drain_ign got st=%0d lvl=%0d drop=%0d exp 2/5/4",
               state_o, level, drop_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      rd_req = 1'b1;
      tick();
      checks++;
      if (i < 4) begin
        if (state_o !== 2'd2 || done !== 1'b0 || level !== 5'(4 - i)) begin
          errs++;
          $display("FAIL drain_pop%0d got st=%0d dn=%b lvl=%0d exp 2/0/%0d",
                   i, state_o, done, level, 4 - i);
        end
      end else begin
        if (state_o !== 2'd3 || done !== 1'b1 || level !== 5'd0) begin
          errs++;
          $display("FAIL drain_done got st=%0d dn=%b lvl=%0d exp 3/1/0",
                   state_o, done, level);
        end
      end
    end
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== ent(4'hF, 30'd5)) begin
      errs++;
      $display("FAIL empty_pop got rv=%b d=%h exp rv=0 d=%h",
               rd_valid, rd_data, ent(4'hF, 30'd5));
    end
  endtask

  task automatic test_reset_mid;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (state_o !== 2'd1 || overflow !== 1'b0 || drop_cnt !== 16'd0
        || done !== 1'b0) begin
      errs++;
      $display("FAIL rearm got st=%0d ov=%b drop=%0d dn=%b exp 1/0/0/0",
               state_o, overflow, drop_cnt, done);
    end
    dct_valid = 1'b1;
    dct_count = 4'd1;
    dct_buffer = 30'd0;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (level !== 5'd1 || rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL empty_pp got lvl=%0d rv=%b exp 1/0", level, rd_valid);
    end
    for (int i = 0; i < 7; i++) begin
      dct_buffer = 30'(i + 1);
      tick();
    end
    dct_valid = 1'b0;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (level !== 5'd7 || rd_valid !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst got lvl=%0d rv=%b exp 7/1", level, rd_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd0 || level !== 5'd0 || rd_valid !== 1'b0
        || overflow !== 1'b0) begin
      errs++;
      $display("FAIL async_rst got st=%0d lvl=%0d rv=%b ov=%b exp 0/0/0/0",
               state_o, level, rd_valid, overflow);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_check;
    logic [2:0]  exp_lvl;
    logic [31:0] exp_d;
    b_arm = 1'b1;
    tick();
    b_arm = 1'b0;
    b_valid = 1'b1;
    b_cnt = 4'd0;
    b_buf = 28'h1;
    tick();
    checks++;
    if (b_level !== 3'd0 || b_perr !== 1'b0) begin
      errs++;
      $display("FAIL cnt0 got lvl=%0d pe=%b exp 0/0", b_level, b_perr);
    end
    b_cnt = 4'd15;
    b_buf = 28'hABCDEF1;
    tick();
`ifdef OCI_TRACE_CHECK_EN
    exp_lvl = 3'd0;
    checks++;
    if (b_level !== 3'd0 || b_perr !== 1'b1 || b_drop !== 16'd0) begin
      errs++;
      $display("FAIL range got lvl=%0d pe=%b drop=%0d exp 0/1/0",
               b_level, b_perr, b_drop);
    end
    exp_d = {4'd14, 28'h0000042};
`else
    exp_lvl = 3'd1;
    checks++;
    if (b_level !== 3'd1 || b_perr !== 1'b0 || b_drop !== 16'd0) begin
      errs++;
      $display("FAIL range got lvl=%0d pe=%b drop=%0d exp 1/0/0",
               b_level, b_perr, b_drop);
    end
    exp_d = {4'd15, 28'hABCDEF1};
`endif
    b_cnt = 4'd14;
    b_buf = 28'h0000042;
    tick();
    b_valid = 1'b0;
    checks++;
    if (b_level !== exp_lvl + 3'd1) begin
      errs++;
      $display("FAIL cnt14 got lvl=%0d exp=%0d", b_level, exp_lvl + 3'd1);
    end
    b_rd_req = 1'b1;
    tick();
    b_rd_req = 1'b0;
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== exp_d) begin
      errs++;
      $display("FAIL chk_rd got rv=%b d=%h exp=%h", b_rd_valid, b_rd_data, exp_d);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errs++;
      $display("FAIL main_perr got=%b exp=0", proto_err);
    end
  endtask

  initial begin
    arm = 1'b0;
    dct_valid = 1'b0;
    dct_buffer = '0;
    dct_count = '0;
    test_ending = 1'b0;
    test_has_ended = 1'b0;
    rd_req = 1'b0;
    b_arm = 1'b0;
    b_valid = 1'b0;
    b_buf = '0;
    b_cnt = '0;
    b_rd_req = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_drain();
    test_reset_mid();
    test_check();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
